// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM state codes, grant owners,
// byte-enable codes and the grant selection helper.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_GNT_M = 1'b0,
        ARB_GNT_D = 1'b1
    } arb_gnt_e;

    localparam logic [3:0] BE_NONE  = 4'b0000;
    localparam logic [3:0] BE_BYTE0 = 4'b0001;
    localparam logic [3:0] BE_BYTE1 = 4'b0010;
    localparam logic [3:0] BE_BYTE2 = 4'b0100;
    localparam logic [3:0] BE_BYTE3 = 4'b1000;
    localparam logic [3:0] BE_HALF0 = 4'b0011;
    localparam logic [3:0] BE_HALF1 = 4'b1100;
    localparam logic [3:0] BE_WORD  = 4'b1111;

    // Winner for the current IDLE cycle; on a tie with rr_en set the port that did
    // not win last time gets the grant, otherwise M has priority.
    function automatic arb_gnt_e arb_pick(input logic m_req, input logic d_req,
                                          input arb_gnt_e last_gnt, input logic rr_en);
        arb_gnt_e win;
        win = ARB_GNT_M;
        if (m_req && d_req) begin
            if (rr_en && (last_gnt == ARB_GNT_M)) win = ARB_GNT_D;
        end else if (d_req) begin
            win = ARB_GNT_D;
        end
        return win;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_wait_counter.sv
// Access wait counter: loads WAIT_CYCLES when an access starts, counts down to zero.
// full marks the first ACCESS cycle, zero marks the last one.
module mem_bus_arbiter_wait_counter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic zero,
    output logic full
);

    localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_CYCLES);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= LOAD_VAL;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign zero = (cnt_q == '0);
    assign full = (cnt_q == LOAD_VAL);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master (CPU M-stage / secondary D) arbiter for the single data-memory port.
// Build option: ARB_ROUND_ROBIN_EN selects alternating grants on a tie instead of M>D.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int AW          = 32,
    parameter int DW          = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            m_req,
    input  logic            m_we,
    input  logic [AW-1:0]   m_addr,
    input  logic [DW-1:0]   m_wdata,
    input  logic [DW/8-1:0] m_be,
    output logic [DW-1:0]   m_rdata,
    output logic            m_done,
    output logic            m_stall,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic [DW-1:0]   d_rdata,
    output logic            d_done,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic [DW-1:0]   mem_rdata,
    output arb_state_e      dbg_state
);

    arb_state_e      state_q, state_d;
    arb_gnt_e        gnt_q, win;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW/8-1:0] be_q;
    logic [DW-1:0]   m_rdata_q, d_rdata_q;
    logic            start, capture;
    logic            cnt_zero, cnt_full;

`ifdef ARB_ROUND_ROBIN_EN
    arb_gnt_e last_gnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= ARB_GNT_D;
        end else if (start) begin
            last_gnt_q <= win;
        end
    end

    assign win = arb_pick(m_req, d_req, last_gnt_q, 1'b1);
`else
    assign win = arb_pick(m_req, d_req, ARB_GNT_D, 1'b0);
`endif

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        capture = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (m_req || d_req) begin
                    start   = 1'b1;
                    state_d = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                if (cnt_zero) begin
                    capture = 1'b1;
                    state_d = ARB_DONE;
                end
            end
            // No arbitration here: every transaction ends with a one-cycle bubble.
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            gnt_q     <= ARB_GNT_M;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            m_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                gnt_q   <= win;
                we_q    <= (win == ARB_GNT_D) ? d_we    : m_we;
                addr_q  <= (win == ARB_GNT_D) ? d_addr  : m_addr;
                wdata_q <= (win == ARB_GNT_D) ? d_wdata : m_wdata;
                be_q    <= (win == ARB_GNT_D) ? d_be    : m_be;
            end
            if (capture && !we_q) begin
                if (gnt_q == ARB_GNT_M) m_rdata_q <= mem_rdata;
                else                    d_rdata_q <= mem_rdata;
            end
        end
    end

    mem_bus_arbiter_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start),
        .dec   (state_q == ARB_ACCESS),
        .zero  (cnt_zero),
        .full  (cnt_full)
    );

    // The counter still holds its load value only in the first ACCESS cycle.
    assign mem_en    = (state_q == ARB_ACCESS);
    assign mem_we    = mem_en && we_q && cnt_full;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;

    assign m_done    = (state_q == ARB_DONE) && (gnt_q == ARB_GNT_M);
    assign d_done    = (state_q == ARB_DONE) && (gnt_q == ARB_GNT_D);
    assign m_stall   = m_req && !m_done;
    assign m_rdata   = m_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table of single transactions plus
// hand sequences for ties, mid-access address change, zero wait and reset mid-access.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int W  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // main DUT (WAIT_CYCLES=2)
    logic          m_req, m_we, d_req, d_we;
    logic [31:0]   m_addr, m_wdata, d_addr, d_wdata, mem_rdata;
    logic [3:0]    m_be, d_be;
    logic [31:0]   m_rdata, d_rdata, mem_addr, mem_wdata;
    logic          m_done, m_stall, d_done, mem_en, mem_we;
    logic [3:0]    mem_be;
    arb_state_e    dbg_state;

    // zero-wait DUT
    logic          m0_req, d0_req;
    logic [31:0]   d0_addr, mem0_rdata;
    logic [31:0]   m0_rdata, d0_rdata, mem0_addr, mem0_wdata;
    logic          m0_done, m0_stall, d0_done, mem0_en, mem0_we;
    logic [3:0]    mem0_be;
    arb_state_e    dbg0_state;

    mem_bus_arbiter #(.WAIT_CYCLES(W), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_rdata(m_rdata), .m_done(m_done), .m_stall(m_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    mem_bus_arbiter #(.WAIT_CYCLES(0), .AW(AW), .DW(DW)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .m_req(m0_req), .m_we(1'b0), .m_addr(32'h0), .m_wdata(32'h0), .m_be(4'h0),
        .m_rdata(m0_rdata), .m_done(m0_done), .m_stall(m0_stall),
        .d_req(d0_req), .d_we(1'b0), .d_addr(d0_addr), .d_wdata(32'h0), .d_be(4'hF),
        .d_rdata(d0_rdata), .d_done(d0_done),
        .mem_en(mem0_en), .mem_we(mem0_we), .mem_addr(mem0_addr), .mem_wdata(mem0_wdata),
        .mem_be(mem0_be), .mem_rdata(mem0_rdata), .dbg_state(dbg0_state)
    );

    // scoreboard
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_prev, d_prev;
    bit            last_d;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pop_exp();
        logic [31:0] v;
        v = 32'hBAD0_BAD0;
        if (exp_q.size() != 0) v = exp_q.pop_front();
        return v;
    endfunction

    typedef struct {
        bit          pd;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] mval;
    } vec_t;

    vec_t vecs[6];

    // driver: one transaction on port M (pd=0) or D (pd=1), held until done
    task automatic run_txn(input bit pd, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           input logic [31:0] mval);
        int  lat = 0;
        int  en_n = 0;
        int  we_n = 0;
        bit  seen = 0;
        logic [31:0] exp;
        @(negedge clk);
        mem_rdata = mval;
        if (pd) begin
            d_we = we; d_addr = addr; d_wdata = wdata; d_be = be; d_req = 1'b1;
            exp = we ? d_prev : mval;
            d_prev = exp;
        end else begin
            m_we = we; m_addr = addr; m_wdata = wdata; m_be = be; m_req = 1'b1;
            exp = we ? m_prev : mval;
            m_prev = exp;
        end
        exp_q.push_back(exp);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (mem_en) en_n++;
            if (mem_we) we_n++;
            if (i == 1) begin
                chk("mem_addr", mem_addr, addr);
                chk("mem_wdata", mem_wdata, wdata);
                chk("mem_be", {28'h0, mem_be}, {28'h0, be});
                chk("mem_we_first", {31'h0, mem_we}, {31'h0, we});
                if (!pd) chk("m_stall_busy", {31'h0, m_stall}, 32'h1);
            end
            if (pd ? d_done : m_done) begin
                seen = 1;
                lat = i;
                break;
            end
        end
        chk("done_seen", {31'h0, seen}, 32'h1);
        chk("latency", 32'(lat), 32'(W + 2));
        chk("mem_en_cycles", 32'(en_n), 32'(W + 1));
        chk("mem_we_cycles", 32'(we_n), we ? 32'h1 : 32'h0);
        chk(pd ? "d_rdata" : "m_rdata", pd ? d_rdata : m_rdata, pop_exp());
        if (!pd) chk("m_stall_done", {31'h0, m_stall}, 32'h0);
        @(posedge clk); #1;
        chk("done_pulse_width", {31'h0, (pd ? d_done : m_done)}, 32'h0);
        if (pd) d_req = 1'b0; else m_req = 1'b0;
        last_d = pd;
    endtask

    // both ports request reads in the same IDLE cycle
    task automatic run_tie(input bit d_first, input logic [31:0] v1, input logic [31:0] v2);
        int m_at = 0;
        int d_at = 0;
        bit m_drop = 0;
        bit d_drop = 0;
        @(negedge clk);
        mem_rdata = v1;
        m_we = 1'b0; m_addr = 32'h60; m_req = 1'b1;
        d_we = 1'b0; d_addr = 32'h64; d_req = 1'b1;
        exp_q.push_back(v1);
        exp_q.push_back(v2);
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (m_drop) m_req = 1'b0;
            if (d_drop) d_req = 1'b0;
            if (m_done && m_at == 0) begin
                m_at = i; m_drop = 1; mem_rdata = v2;
                chk("tie_m_rdata", m_rdata, pop_exp());
            end
            if (d_done && d_at == 0) begin
                d_at = i; d_drop = 1; mem_rdata = v2;
                chk("tie_d_rdata", d_rdata, pop_exp());
            end
            if (m_at != 0 && d_at != 0) break;
        end
        chk("tie_m_done_at", 32'(m_at), d_first ? 32'(2 * W + 5) : 32'(W + 2));
        chk("tie_d_done_at", 32'(d_at), d_first ? 32'(W + 2) : 32'(2 * W + 5));
        @(posedge clk); #1;
        m_req = 1'b0; d_req = 1'b0;
        m_prev = d_first ? v2 : v1;
        d_prev = d_first ? v1 : v2;
        last_d = !d_first;
    endtask

    function automatic bit tie_expect_d_first();
`ifdef ARB_ROUND_ROBIN_EN
        return !last_d;
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        rst_n = 1'b0;
        m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_be = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        mem_rdata = 0;
        m0_req = 0; d0_req = 0; d0_addr = 0; mem0_rdata = 0;
        m_prev = 0; d_prev = 0; last_d = 1'b1;

        vecs[0] = '{pd: 0, we: 0, addr: 32'h10, wdata: 32'h0, be: BE_WORD, mval: 32'hDEADBEEF};
        vecs[1] = '{pd: 0, we: 1, addr: 32'h20, wdata: 32'h12345678, be: BE_WORD, mval: $urandom};
        vecs[2] = '{pd: 1, we: 0, addr: 32'h30, wdata: 32'h0, be: BE_WORD, mval: $urandom};
        vecs[3] = '{pd: 1, we: 1, addr: 32'h34, wdata: $urandom, be: BE_HALF0, mval: $urandom};
        vecs[4] = '{pd: 0, we: 0, addr: 32'h44, wdata: 32'h0, be: BE_BYTE2, mval: $urandom};
        vecs[5] = '{pd: 1, we: 0, addr: {$urandom_range(255, 0), 2'b00}, wdata: 32'h0,
                    be: BE_WORD, mval: $urandom};

        repeat (2) @(negedge clk);
        chk("rst_state", {30'h0, dbg_state}, {30'h0, ARB_IDLE});
        chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_m_rdata", m_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_done", {30'h0, m_done, d_done}, 32'h0);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++)
            run_txn(vecs[v].pd, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].be, vecs[v].mval);

        run_tie(tie_expect_d_first(), 32'hA1A1_0001, 32'hB2B2_0002);
        run_txn(1'b0, 1'b0, 32'h48, 32'h0, BE_WORD, 32'h0BAD_F00D);
        run_tie(tie_expect_d_first(), 32'hC3C3_0003, 32'hD4D4_0004);

        // address changed while the access is in flight
        begin
            bit seen = 0;
            @(negedge clk);
            mem_rdata = 32'h5555_AAAA;
            m_we = 1'b0; m_addr = 32'h40; m_be = BE_WORD; m_req = 1'b1;
            exp_q.push_back(32'h5555_AAAA);
            m_prev = 32'h5555_AAAA;
            for (int i = 1; i <= 20; i++) begin
                @(posedge clk); #1;
                if (i == 1) begin m_addr = 32'hFFFF_0000; m_be = BE_BYTE0; end
                if (mem_en || m_done) chk("held_mem_addr", mem_addr, 32'h40);
                if (m_done) begin seen = 1; break; end
            end
            chk("held_done_seen", {31'h0, seen}, 32'h1);
            chk("held_m_rdata", m_rdata, pop_exp());
            @(posedge clk); #1;
            m_req = 1'b0;
            last_d = 1'b0;
        end

        // zero wait cycles, D read
        begin
            int lat = 0;
            int en_n = 0;
            @(negedge clk);
            mem0_rdata = 32'h0F0F_1234; d0_addr = 32'h70; d0_req = 1'b1;
            exp_q.push_back(32'h0F0F_1234);
            for (int i = 1; i <= 20; i++) begin
                @(posedge clk); #1;
                if (mem0_en) en_n++;
                if (d0_done) begin lat = i; break; end
            end
            chk("w0_latency", 32'(lat), 32'h2);
            chk("w0_mem_en_cycles", 32'(en_n), 32'h1);
            chk("w0_d_rdata", d0_rdata, pop_exp());
            @(posedge clk); #1;
            d0_req = 1'b0;
        end

        // reset asserted in the second ACCESS cycle of an M write
        begin
            int done_n = 0;
            @(negedge clk);
            m_we = 1'b1; m_addr = 32'h80; m_wdata = 32'hCAFE_0000; m_be = BE_WORD; m_req = 1'b1;
            @(posedge clk); #1;
            @(posedge clk); #1;
            chk("pre_rst_mem_en", {31'h0, mem_en}, 32'h1);
            rst_n = 1'b0;
            #1;
            chk("mid_rst_mem_en", {31'h0, mem_en}, 32'h0);
            chk("mid_rst_mem_we", {31'h0, mem_we}, 32'h0);
            chk("mid_rst_state", {30'h0, dbg_state}, {30'h0, ARB_IDLE});
            chk("mid_rst_m_done", {31'h0, m_done}, 32'h0);
            chk("mid_rst_m_rdata", m_rdata, 32'h0);
            m_req = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            m_prev = 0; d_prev = 0; last_d = 1'b1;
            for (int i = 0; i < 6; i++) begin
                @(posedge clk); #1;
                if (m_done || d_done) done_n++;
            end
            chk("post_rst_no_done", 32'(done_n), 32'h0);
        end

        run_txn(1'b0, 1'b0, 32'h90, 32'h0, BE_WORD, 32'h7777_8888);

        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
